pwm_breathe_mc: RTL

PWM_BREATHE_MC -- requirements
Module: pwm_breathe_mc

---
 rtl/pwm_breathe_mc.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pwm_breathe_mc.sv
// pwm_breathe_mc: multi-channel LED PWM driver with off / fixed / breathe / blink
// modes. A shared frame counter drives all channels; per-channel configuration
// is written into shadow registers and only becomes active on a frame boundary.
// Optional feature macro: PWM_PHASE_EN staggers the breathe start level per channel.
module pwm_breathe_mc #(
    parameter int CH     = 4,
    parameter int CW     = 13,
    parameter int PERIOD = 7071
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          cfg_wr,
    input  logic [3:0]    cfg_ch,
    input  logic [1:0]    cfg_mode,
    input  logic [CW-1:0] cfg_duty,
    output logic [CH-1:0] led,
    output logic          frame_tick
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_FIXED   = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_BLINK   = 2'b11
    } mode_t;

    localparam logic [CW-1:0] PER      = CW'(PERIOD);
    localparam logic [CW-1:0] LAST     = CW'(PERIOD - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(PERIOD - 2);

    logic [CW-1:0] fc_reg;
    logic          tick_reg;

    // Shared frame counter; the tick register is kept aligned with fc == PERIOD-1.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fc_reg   <= '0;
            tick_reg <= 1'b0;
        end else begin
            fc_reg   <= (fc_reg == LAST) ? '0 : fc_reg + CW'(1);
            tick_reg <= (fc_reg == PRE_LAST);
        end
    end

    assign frame_tick = tick_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
`ifdef PWM_PHASE_EN
            localparam logic [CW-1:0] BR_START = CW'((gi * (PERIOD - 1)) / CH);
`else
            localparam logic [CW-1:0] BR_START = '0;
`endif
            mode_t         sh_mode_reg;
            mode_t         act_mode_reg;
            logic [CW-1:0] sh_duty_reg;
            logic [CW-1:0] act_duty_reg;
            logic [CW-1:0] lvl_reg;
            logic [CW-1:0] bcnt_reg;
            logic          dir_down_reg;
            logic          blink_reg;
            logic          led_reg;
            logic          wr_hit;
            logic [CW-1:0] fix_lvl;
            logic [CW-1:0] blink_len;

            assign wr_hit    = cfg_wr && (cfg_ch == 4'(gi));
            assign fix_lvl   = (sh_duty_reg >= PER) ? PER : sh_duty_reg;
            assign blink_len = (act_duty_reg == '0) ? CW'(1) : act_duty_reg;

            // Shadow configuration captured on a matching write strobe.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    sh_mode_reg <= MODE_OFF;
                    sh_duty_reg <= '0;
                end else if (wr_hit) begin
                    sh_mode_reg <= mode_t'(cfg_mode);
                    sh_duty_reg <= cfg_duty;
                end
            end

            // On each frame boundary: activate the shadow config and step the level.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    act_mode_reg <= MODE_OFF;
                    act_duty_reg <= '0;
                    lvl_reg      <= '0;
                    bcnt_reg     <= '0;
                    dir_down_reg <= 1'b0;
                    blink_reg    <= 1'b0;
                end else if (tick_reg) begin
                    act_mode_reg <= sh_mode_reg;
                    act_duty_reg <= sh_duty_reg;
                    if (sh_mode_reg != act_mode_reg) begin
                        // Mode change restarts the channel from its start state.
                        dir_down_reg <= 1'b0;
                        blink_reg    <= 1'b0;
                        bcnt_reg     <= '0;
                        case (sh_mode_reg)
                            MODE_OFF:     lvl_reg <= '0;
                            MODE_FIXED:   lvl_reg <= fix_lvl;
                            MODE_BREATHE: lvl_reg <= BR_START;
                            MODE_BLINK:   lvl_reg <= '0;
                        endcase
                    end else begin
                        case (sh_mode_reg)
                            MODE_OFF:   lvl_reg <= '0;
                            MODE_FIXED: lvl_reg <= fix_lvl;
                            MODE_BREATHE: begin
                                if (!dir_down_reg) begin
                                    lvl_reg <= lvl_reg + CW'(1);
                                    if (lvl_reg + CW'(1) == LAST) dir_down_reg <= 1'b1;
                                end else begin
                                    lvl_reg <= lvl_reg - CW'(1);
                                    if (lvl_reg - CW'(1) == '0) dir_down_reg <= 1'b0;
                                end
                            end
                            MODE_BLINK: begin
                                if (bcnt_reg + CW'(1) >= blink_len) begin
                                    bcnt_reg  <= '0;
                                    blink_reg <= ~blink_reg;
                                    lvl_reg   <= blink_reg ? '0 : PER;
                                end else begin
                                    bcnt_reg  <= bcnt_reg + CW'(1);
                                end
                            end
                        endcase
                    end
                end
            end

            // Registered PWM compare, one clock behind the frame counter.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    led_reg <= 1'b0;
                end else begin
                    led_reg <= (fc_reg < lvl_reg);
                end
            end

            assign led[gi] = led_reg;
        end
    endgenerate
endmodule
